// File: rtl/cobs_decode_if.sv
// -----------------------------------------------------------------------------
// cobs_decode_if
//
// 8-bit AXI-Stream bundle used on both sides of the COBS decoder.
//
// Signals:
//   tdata  [7:0]  byte being transferred
//   tvalid        source presents a byte
//   tready        sink accepts the byte
//   tlast         final byte of a frame (ignored by the decoder's input side)
//   tuser         frame error flag, meaningful only together with tlast
//
// Modports:
//   master  drives tdata/tvalid/tlast/tuser, samples tready
//   slave   samples tdata/tvalid/tlast, drives tready
// -----------------------------------------------------------------------------
interface cobs_decode_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/cobs_decode.sv
// -----------------------------------------------------------------------------
// cobs_decode
//
// Streaming COBS decoder. Consumes a COBS-encoded byte stream in which 0x00
// delimits frames and produces the raw payload with tlast on the final byte
// of every frame. A frame that ends in the middle of a block is flagged with
// tuser on its last byte and a one-cycle decode_error pulse.
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   s_axis        encoded input stream (slave); tlast is ignored
//   m_axis        decoded output stream (master); tuser = frame error
//   decode_error  one-cycle pulse after a truncated frame's delimiter
// -----------------------------------------------------------------------------
module cobs_decode (
    input  logic         clk,
    input  logic         rst_n,
    cobs_decode_if.slave  s_axis,
    cobs_decode_if.master m_axis,
    output logic         decode_error
);

    typedef enum logic {
        WAIT_CODE = 1'b0,
        DATA      = 1'b1
    } state_t;

    // Registered state
    state_t      r_state;
    logic [7:0]  r_count;
    logic        r_code_ff;
    logic        r_first_block;
    logic        r_hold_valid;
    logic [7:0]  r_hold_data;
    logic [7:0]  r_tdata;
    logic        r_tvalid;
    logic        r_tlast;
    logic        r_tuser;
    logic        r_decode_error;

    // Next-state values
    state_t      w_state_nxt;
    logic [7:0]  w_count_nxt;
    logic        w_code_ff_nxt;
    logic        w_first_block_nxt;
    logic        w_hold_valid_nxt;
    logic [7:0]  w_hold_data_nxt;
    logic [7:0]  w_tdata_nxt;
    logic        w_tvalid_nxt;
    logic        w_tlast_nxt;
    logic        w_tuser_nxt;
    logic        w_decode_error_nxt;

    // Per-byte decode results
    logic        w_ready;
    logic        w_accept;
    logic        w_is_zero;
    logic        w_produce;
    logic [7:0]  w_prod_byte;
    logic        w_frame_end;
    logic        w_frame_err;

    // Each input byte yields at most one output byte, so the input can be
    // accepted whenever the output register is empty or being drained.
    assign w_ready   = rst_n & (~r_tvalid | m_axis.tready);
    assign w_accept  = s_axis.tvalid & w_ready;
    assign w_is_zero = (s_axis.tdata == 8'h00);

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        w_count_nxt        = r_count;
        w_code_ff_nxt      = r_code_ff;
        w_first_block_nxt  = r_first_block;
        w_hold_valid_nxt   = r_hold_valid;
        w_hold_data_nxt    = r_hold_data;
        w_tdata_nxt        = r_tdata;
        w_tvalid_nxt       = r_tvalid & ~m_axis.tready;
        w_tlast_nxt        = r_tlast;
        w_tuser_nxt        = r_tuser;
        w_decode_error_nxt = 1'b0;
        w_produce          = 1'b0;
        w_prod_byte        = '0;
        w_frame_end        = 1'b0;
        w_frame_err        = 1'b0;

        if (w_accept) begin
            unique case (r_state)
                WAIT_CODE: begin
                    if (w_is_zero) begin
                        w_frame_end = 1'b1;
                    end else begin
                        // The zero that separated the previous block from
                        // this one, unless that block was a full 0xFF block.
                        if (!r_first_block && !r_code_ff) begin
                            w_produce   = 1'b1;
                            w_prod_byte = 8'h00;
                        end
                        w_count_nxt       = s_axis.tdata - 8'd1;
                        w_code_ff_nxt     = (s_axis.tdata == 8'hFF);
                        w_first_block_nxt = 1'b0;
                        w_state_nxt       = (s_axis.tdata != 8'h01) ? DATA : WAIT_CODE;
                    end
                end
                DATA: begin
                    if (w_is_zero) begin
                        w_frame_end        = 1'b1;
                        w_frame_err        = 1'b1;
                        w_decode_error_nxt = 1'b1;
                    end else begin
                        w_produce   = 1'b1;
                        w_prod_byte = s_axis.tdata;
                        w_count_nxt = r_count - 8'd1;
                        if (r_count == 8'd1) begin
                            w_state_nxt = WAIT_CODE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = WAIT_CODE;
                end
            endcase

            // One byte of lookahead: a new byte pushes the held byte out as
            // a non-final byte, and the frame end flushes it as the last one.
            if (w_produce) begin
                if (r_hold_valid) begin
                    w_tdata_nxt  = r_hold_data;
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = 1'b0;
                    w_tuser_nxt  = 1'b0;
                end
                w_hold_data_nxt  = w_prod_byte;
                w_hold_valid_nxt = 1'b1;
            end

            if (w_frame_end) begin
                if (r_hold_valid) begin
                    w_tdata_nxt  = r_hold_data;
                    w_tvalid_nxt = 1'b1;
                    w_tlast_nxt  = 1'b1;
                    w_tuser_nxt  = w_frame_err;
                end
                w_hold_valid_nxt  = 1'b0;
                w_first_block_nxt = 1'b1;
                w_code_ff_nxt     = 1'b0;
                w_count_nxt       = '0;
                w_state_nxt       = WAIT_CODE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= WAIT_CODE;
            r_count        <= '0;
            r_code_ff      <= 1'b0;
            r_first_block  <= 1'b1;
            r_hold_valid   <= 1'b0;
            r_hold_data    <= '0;
            r_tdata        <= '0;
            r_tvalid       <= 1'b0;
            r_tlast        <= 1'b0;
            r_tuser        <= 1'b0;
            r_decode_error <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_count        <= w_count_nxt;
            r_code_ff      <= w_code_ff_nxt;
            r_first_block  <= w_first_block_nxt;
            r_hold_valid   <= w_hold_valid_nxt;
            r_hold_data    <= w_hold_data_nxt;
            r_tdata        <= w_tdata_nxt;
            r_tvalid       <= w_tvalid_nxt;
            r_tlast        <= w_tlast_nxt;
            r_tuser        <= w_tuser_nxt;
            r_decode_error <= w_decode_error_nxt;
        end
    end

    assign s_axis.tready = w_ready;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign m_axis.tuser  = r_tuser;
    assign decode_error  = r_decode_error;

endmodule

// File: tb/tb_cobs_decode.sv
module tb_cobs_decode;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic decode_error;

    always #5 clk = ~clk;

    cobs_decode_if s_if ();
    cobs_decode_if m_if ();

    cobs_decode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .decode_error (decode_error)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       user;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pulses_exp = 0;
    int   pulses_seen = 0;
    int   rdy_mode = 0;      // 0: always ready, 1: 1,0,0,1 pattern, 2: random, 3: never
    int   rdy_phase = 0;
    logic       was_stalled = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference decoder: plain COBS rules applied to one frame's encoded bytes.
    task automatic model_frame(input logic [7:0] enc[$]);
        logic [7:0] out[$];
        int         i;
        int         c;
        logic       err;
        exp_t       e;
        out = {};
        i   = 0;
        err = 1'b0;
        while (i < enc.size() && !err) begin
            c = enc[i];
            i++;
            for (int k = 1; k < c; k++) begin
                if (i < enc.size()) begin
                    out.push_back(enc[i]);
                    i++;
                end else begin
                    err = 1'b1;
                    break;
                end
            end
            if (!err && i < enc.size() && c != 255) out.push_back(8'h00);
        end
        if (err) pulses_exp++;
        for (int j = 0; j < out.size(); j++) begin
            e.d    = out[j];
            e.last = (j == out.size() - 1);
            e.user = e.last ? err : 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic cobs_enc(input logic [7:0] raw[$], output logic [7:0] enc[$]);
        int code_idx;
        int code;
        enc = {};
        enc.push_back(8'h00);
        code_idx = 0;
        code = 1;
        foreach (raw[j]) begin
            if (raw[j] == 8'h00) begin
                enc[code_idx] = code[7:0];
                code_idx = enc.size();
                enc.push_back(8'h00);
                code = 1;
            end else begin
                enc.push_back(raw[j]);
                code++;
                if (code == 255) begin
                    enc[code_idx] = 8'hFF;
                    code_idx = enc.size();
                    enc.push_back(8'h00);
                    code = 1;
                end
            end
        end
        enc[code_idx] = code[7:0];
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        s_if.tdata  = b;
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'($urandom_range(0, 1));
        @(negedge clk);
        while (!s_if.tready && t < 2000) begin
            t++;
            @(negedge clk);
        end
        if (t >= 2000) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: byte %0h not accepted in 2000 cycles", b);
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] enc[$], input bit gaps);
        model_frame(enc);
        foreach (enc[j]) begin
            send(enc[j]);
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        send(8'h00);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_done", (sb.size() == 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Downstream ready generator.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_if.tready = 1'b1;
            1: begin
                m_if.tready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                rdy_phase++;
            end
            2: m_if.tready = 1'($urandom_range(0, 1));
            default: m_if.tready = 1'b0;
        endcase
    end

    // Monitor / scoreboard checker.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            was_stalled = 1'b0;
        end else begin
            if (m_if.tvalid && !m_if.tready) chk("s_tready_low_when_stalled", s_if.tready, 0);
            if (!m_if.tvalid) chk("s_tready_high_when_empty", s_if.tready, 1);
            if (was_stalled) begin
                chk("stall_tvalid_held", m_if.tvalid, 1);
                chk("stall_tdata_stable", m_if.tdata, stall_data);
                chk("stall_tlast_stable", m_if.tlast, stall_last);
            end
            was_stalled = m_if.tvalid && !m_if.tready;
            stall_data  = m_if.tdata;
            stall_last  = m_if.tlast;
            if (m_if.tvalid && m_if.tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected no byte", m_if.tdata);
                end else begin
                    e = sb.pop_front();
                    chk("tdata", m_if.tdata, e.d);
                    chk("tlast", m_if.tlast, e.last);
                    if (e.last) chk("tuser", m_if.tuser, e.user);
                end
            end
            if (decode_error) pulses_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] enc[$];
        logic [7:0] raw[$];
        int n;

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b1;
        #12;
        chk("rst_tvalid", m_if.tvalid, 0);
        chk("rst_tdata", m_if.tdata, 0);
        chk("rst_tlast", m_if.tlast, 0);
        chk("rst_tuser", m_if.tuser, 0);
        chk("rst_decode_error", decode_error, 0);
        chk("rst_s_tready", s_if.tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_tready", s_if.tready, 1);

        // Basic frame with an implied zero.
        enc = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33};
        send_frame(enc, 0);
        drain();

        // Single zero, empty frame, bare delimiter.
        enc = '{8'h01, 8'h01};
        send_frame(enc, 0);
        enc = '{8'h01};
        send_frame(enc, 0);
        enc = {};
        send_frame(enc, 0);
        drain();

        // Full 0xFF block: no inserted zero.
        enc = {};
        enc.push_back(8'hFF);
        for (int v = 1; v <= 254; v++) enc.push_back(8'(v));
        enc.push_back(8'h01);
        send_frame(enc, 0);
        drain();

        // Truncated frame followed by a good one.
        enc = '{8'h04, 8'hAA, 8'hBB};
        model_frame(enc);
        foreach (enc[j]) send(enc[j]);
        send(8'h00);
        chk("decode_error_timing", decode_error, 1);
        enc = '{8'h02, 8'h55};
        send_frame(enc, 0);
        drain();

        // Backpressure pattern on the basic frame.
        rdy_mode = 1;
        enc = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33};
        send_frame(enc, 0);
        drain();

        // Asynchronous reset mid-frame with bytes held inside the decoder.
        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        send(8'h05);
        send(8'h10);
        send(8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", m_if.tvalid, 0);
        chk("midrst_tdata", m_if.tdata, 0);
        chk("midrst_tlast", m_if.tlast, 0);
        chk("midrst_s_tready", s_if.tready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        enc = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33};
        send_frame(enc, 0);
        drain();

        // Randomized frames with random backpressure.
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                enc = {};
                n = $urandom_range(1, 10);
                for (int j = 0; j < n; j++) enc.push_back(8'($urandom_range(1, 255)));
            end else begin
                raw = {};
                n = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 300) : $urandom_range(0, 30);
                for (int j = 0; j < n; j++)
                    raw.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                cobs_enc(raw, enc);
            end
            send_frame(enc, 1);
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        chk("idle_tvalid", m_if.tvalid, 0);
        chk("decode_error_pulses", pulses_seen, pulses_exp);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cobs_decode.md
# cobs_decode

Streaming COBS decoder: accepts a COBS-encoded byte stream with 0x00 frame delimiters on an 8-bit AXI-Stream slave and emits the raw payload bytes on an 8-bit AXI-Stream master, with tlast on the final byte of each frame. It is the receive-side counterpart of the COBS encode path. It sits between the host-link byte receiver and the packet consumers. Malformed frames are flagged, not silently merged.

## Interface
- No parameters. Data width is fixed at 8.
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  encoded byte.
- s_axis_tvalid  in  1  encoded byte valid.
- s_axis_tready  out  1  decoder accepts the byte this cycle.
- s_axis_tlast  in  1  ignored; framing is by 0x00 only.
- m_axis_tdata  out  8  decoded byte.
- m_axis_tvalid  out  1  decoded byte valid.
- m_axis_tready  in  1  downstream accepts.
- m_axis_tlast  out  1  last byte of the decoded frame.
- m_axis_tuser  out  1  frame error; valid only with tlast.
- decode_error  out  1  one-cycle pulse when a truncated frame ends.

## Operation
- States: WAIT_CODE (next byte is a code byte or delimiter) and DATA (inside a block).
- Registers: count[7:0] (data bytes left in block), code_ff, first_block, a hold register (hold_valid, hold_data) and an output register (m_axis_*).
- Hold register: each decoded byte goes into hold. The previous hold content moves to the output register with tlast=0. This keeps one byte of lookahead so tlast lands on the true last byte.
- WAIT_CODE, byte c != 0x00:
  - If !first_block and !code_ff, a decoded 0x00 is produced (implied zero).
  - count = c-1; code_ff = (c==0xFF); first_block = 0.
  - Go to DATA if count != 0, otherwise stay in WAIT_CODE.
- WAIT_CODE, byte 0x00: normal frame end.
- DATA, byte d != 0x00: produce d; count--. Go to WAIT_CODE when count reaches 0.
- DATA, byte 0x00: truncated frame end. Set error; pulse decode_error.
- Frame end, hold_valid=1: move hold to output with tlast=1 and tuser=error; clear hold.
- Frame end, hold empty: emit nothing. This covers an empty frame (e.g. "01 00" or a bare "00") and an error frame with no data.
- Frame end, always: first_block=1, code_ff=0, count=0, state WAIT_CODE.
- At most one output byte is produced per accepted input byte, so no internal overflow is possible.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, decode_error=0, s_axis_tready=0 while rst_n low. Internally: state WAIT_CODE, count=0, first_block=1, code_ff=0, hold empty.
- s_axis_tready = !m_axis_tvalid || m_axis_tready, combinational from the registered m_axis_tvalid. It is 1 after reset with an empty output.
- Input transfer: s_axis_tvalid && s_axis_tready on the rising edge.
- An output byte is held stable until the m_axis_tvalid && m_axis_tready handshake completes.
- Throughput is one input byte per cycle with no backpressure.
- Latency: a decoded byte appears on m_axis the cycle after the next producing input byte or delimiter is accepted. The last byte appears the cycle after the delimiter.
- decode_error asserts in the cycle after the bad delimiter is accepted.
- Reset mid-frame, async: all state cleared immediately; any held or partially decoded byte is discarded; no tlast is emitted for the aborted frame.
- Simultaneous output handshake and input accept in one cycle: the output register reloads with no bubble.

## Test plan
- Input 03 11 22 02 33 00, m_axis_tready=1 -> output 11 22 00 33; tlast only on 33; tuser=0; decode_error never pulses.
- Input 01 01 00 -> single byte 00 with tlast=1. Input 01 00 then 00 -> no output bytes at all.
- Input FF, bytes 01..FE, then 01 00 -> 254 bytes 01..FE, no inserted zero, tlast on FE.
- Input 04 AA BB 00 -> AA, then BB with tlast=1 and tuser=1; one decode_error pulse. Following frame 02 55 00 -> 55 with tlast, tuser=0.
- Backpressure: rerun case 1 with m_axis_tready toggled 1,0,0,1 repeating -> identical byte sequence and tlast. s_axis_tready is low whenever the output is valid and stalled; no byte is lost or duplicated; tdata stable while stalled.
- Assert rst_n low after accepting 05 10 20 -> outputs clear asynchronously. Release and send 03 11 22 02 33 00 -> exactly 11 22 00 33 with tlast on 33, with no stale 10 or 20.
